// File: rtl/intpol2_iq_sink.sv
// Drains len IQ pairs from the interpolator output FIFOs into a result memory,
// packing each pair as {Q,I} at consecutive (wrapping) addresses.
module intpol2_iq_sink #(
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned CONFIG_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start_i,
    input  logic [CONFIG_WIDTH-1:0] len_i,
    input  logic                    Empty_i,
    input  logic [DATA_WIDTH-1:0]   data_I_i,
    input  logic [DATA_WIDTH-1:0]   data_Q_i,
    output logic                    Read_Enable_o,
    output logic                    Write_Enable_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [2*DATA_WIDTH-1:0] data_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CONFIG_WIDTH-1:0] count_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                  state;
    logic [CONFIG_WIDTH-1:0] len_q;
    logic [CONFIG_WIDTH-1:0] rd_cnt;
    logic                    last_rd;

    assign Read_Enable_o = (state == RUN) && !Empty_i && (rd_cnt < len_q);
    assign last_rd       = Read_Enable_o && (rd_cnt == len_q - CONFIG_WIDTH'(1));

    // FIFO read data is registered, so it is valid exactly in the write cycle.
    assign data_o  = Write_Enable_o ? {data_Q_i, data_I_i} : '0;
    assign addr_o  = count_o[ADDR_WIDTH-1:0];
    assign busy_o  = (state == RUN) || (state == DRAIN);
    assign done_o  = (state == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            len_q          <= '0;
            rd_cnt         <= '0;
            count_o        <= '0;
            Write_Enable_o <= 1'b0;
        end else begin
            Write_Enable_o <= Read_Enable_o;
            if (Read_Enable_o) begin
                rd_cnt <= rd_cnt + CONFIG_WIDTH'(1);
            end
            if (Write_Enable_o) begin
                count_o <= count_o + CONFIG_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            len_q   <= len_i;
                            rd_cnt  <= '0;
                            count_o <= '0;
                            state   <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (last_rd) begin
                        state <= DRAIN;
                    end
                end
                DRAIN:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intpol2_iq_sink.sv
// Scoreboard bench for intpol2_iq_sink: a queue-based FIFO model feeds the DUT,
// expected {addr,data} writes are queued at start and checked by a monitor.
module tb_intpol2_iq_sink;

    localparam int DW = 12;
    localparam int AW = 3;
    localparam int CW = 32;

    logic            clk   = 1'b0;
    logic            rstn  = 1'b0;
    logic            start = 1'b0;
    logic [CW-1:0]   len   = '0;
    logic            empty;
    logic [DW-1:0]   d_i   = '0;
    logic [DW-1:0]   d_q   = '0;
    logic            rd_en;
    logic            we;
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] wdata;
    logic            busy;
    logic            done;
    logic [CW-1:0]   count;

    intpol2_iq_sink #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .CONFIG_WIDTH(CW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .start_i       (start),
        .len_i         (len),
        .Empty_i       (empty),
        .data_I_i      (d_i),
        .data_Q_i      (d_q),
        .Read_Enable_o (rd_en),
        .Write_Enable_o(we),
        .addr_o        (addr),
        .data_o        (wdata),
        .busy_o        (busy),
        .done_o        (done),
        .count_o       (count)
    );

    always #5 clk = ~clk;

    // FIFO model with registered read data; gate forces empty to create stalls
    logic [DW-1:0] fi [1024];
    logic [DW-1:0] fq [1024];
    int   wr_idx = 0;
    int   rd_idx = 0;
    logic gate   = 1'b0;

    assign empty = (wr_idx == rd_idx) || gate;

    always @(posedge clk) begin
        if (rd_en) begin
            d_i    <= fi[rd_idx % 1024];
            d_q    <= fq[rd_idx % 1024];
            rd_idx <= rd_idx + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0]   a;
        logic [2*DW-1:0] d;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           e;
    int            errors      = 0;
    int            checks      = 0;
    int            done_cnt    = 0;
    int            exp_done    = 0;
    int            wr_cnt      = 0;
    int            rd_total    = 0;
    int            last_rd_cyc = 0;
    bit            run_read    = 1'b0;
    logic [CW-1:0] exp_final   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: samples 1 time unit after the falling edge
    always @(negedge clk) begin
        #1;
        if (rstn) begin
            if (rd_en) begin
                chk("read_while_empty", {63'd0, empty}, 64'd0);
                last_rd_cyc = cyc;
                run_read    = 1'b1;
                rd_total++;
            end
            if (we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", {61'd0, addr}, {61'd0, e.a});
                    chk("write_data", {40'd0, wdata}, {40'd0, e.d});
                end
            end
            if (done) begin
                chk("done_expected", {63'd0, done_cnt < exp_done}, 64'd1);
                chk("count_at_done", {32'd0, count}, {32'd0, exp_final});
                if (run_read) chk("done_latency", 64'(cyc - last_rd_cyc), 64'd2);
                run_read = 1'b0;
                done_cnt++;
            end
        end
    end

    task automatic push(input logic [DW-1:0] i, input logic [DW-1:0] q);
        fi[wr_idx % 1024] = i;
        fq[wr_idx % 1024] = q;
        wr_idx++;
    endtask

    task automatic push_rand(input int n);
        for (int k = 0; k < n; k++) push(DW'($urandom), DW'($urandom));
    endtask

    // Expected writes are the next n pairs the FIFO delivers, at addr k mod 2**AW
    task automatic start_run(input int n, input bit accept);
        wr_t t;
        @(negedge clk);
        start = 1'b1;
        len   = CW'(n);
        if (accept) begin
            for (int k = 0; k < n; k++) begin
                t.a = AW'(k % (1 << AW));
                t.d = {fq[(rd_idx + k) % 1024], fi[(rd_idx + k) % 1024]};
                exp_q.push_back(t);
            end
            exp_done++;
            if (n > 0) exp_final = CW'(n);
        end
        @(negedge clk);
        start = 1'b0;
        len   = CW'($urandom);
    endtask

    task automatic wait_done(input int mode, input int budget);
        int d0;
        d0 = done_cnt;
        for (int c = 0; c < budget && done_cnt == d0; c++) begin
            @(negedge clk);
            case (mode)
                1:       gate = (cyc % 3) != 0;
                2:       gate = 1'($urandom_range(0, 1));
                default: gate = 1'b0;
            endcase
        end
        gate = 1'b0;
        chk("done_timeout", {63'd0, done_cnt != d0}, 64'd1);
    endtask

    task automatic finish_run(input int d0, input int ndone);
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("busy_after", {63'd0, busy}, 64'd0);
        chk("done_count", 64'(done_cnt - d0), 64'(ndone));
    endtask

    task automatic chk_zero(input string name);
        chk(name, {rd_en, we, busy, done, 29'd0, addr, 8'd0, wdata}, 64'd0);
        chk({name, "_count"}, {32'd0, count}, 64'd0);
    endtask

    initial begin
        int d0;
        int w0;
        int r0;
        int n;

        repeat (2) @(negedge clk);
        chk_zero("reset_state");
        rstn = 1'b1;

        // Basic drain
        for (int k = 0; k < 4; k++) push(DW'(k + 1), DW'(12'h101 + k));
        d0 = done_cnt;
        start_run(4, 1'b1);
        wait_done(0, 50);
        finish_run(d0, 1);
        chk("basic_count", {32'd0, count}, 64'd4);

        // Empty stalls: one sample every third cycle
        push_rand(3);
        gate = 1'b1;
        d0   = done_cnt;
        start_run(3, 1'b1);
        wait_done(1, 100);
        finish_run(d0, 1);

        // Zero length with data available: no reads, immediate done
        push_rand(2);
        d0 = done_cnt;
        r0 = rd_total;
        start_run(0, 1'b1);
        chk("zero_done_next_cycle", {63'd0, done}, 64'd1);
        chk("zero_busy", {63'd0, busy}, 64'd0);
        wait_done(0, 5);
        finish_run(d0, 1);
        chk("zero_no_reads", 64'(rd_total - r0), 64'd0);

        // Start ignored while busy
        push_rand(3);
        d0 = done_cnt;
        start_run(5, 1'b1);
        start_run(2, 1'b0);
        wait_done(0, 50);
        finish_run(d0, 1);
        chk("busy_start_count", {32'd0, count}, 64'd5);

        // Reset mid-transfer
        push_rand(6);
        d0 = done_cnt;
        w0 = wr_cnt;
        start_run(6, 1'b1);
        for (int c = 0; c < 50 && wr_cnt < w0 + 3; c++) @(negedge clk);
        chk("reset_reach_3_writes", {63'd0, wr_cnt >= w0 + 3}, 64'd1);
        #2 rstn = 1'b0;
        #1 chk_zero("mid_reset");
        exp_q.delete();
        exp_done  = done_cnt;
        exp_final = '0;
        @(negedge clk);
        rstn = 1'b1;
        chk("no_done_on_reset", 64'(done_cnt - d0), 64'd0);
        d0 = done_cnt;
        start_run(2, 1'b1);
        wait_done(0, 50);
        finish_run(d0, 1);
        chk("post_reset_count", {32'd0, count}, 64'd2);

        // Address wrap with AW=3
        push_rand(10);
        d0 = done_cnt;
        start_run(10, 1'b1);
        wait_done(0, 60);
        finish_run(d0, 1);
        chk("wrap_count", {32'd0, count}, 64'd10);

        // Random lengths with random empty gating
        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 20));
            push_rand(n);
            d0 = done_cnt;
            start_run(n, 1'b1);
            wait_done(2, 8 * n + 40);
            finish_run(d0, 1);
            chk("rand_count", {32'd0, count}, 64'(n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/intpol2_iq_sink.md
Name: intpol2_iq_sink

Overview:
- Downstream drain stage for the IQ interpolator output FIFOs (I and Q, DC FIFO with registered read data).
- On start, reads exactly len sample pairs from the FIFOs and writes each pair to a result memory at consecutive addresses, packed as {Q,I}.
- Raises a one-cycle done pulse when the last pair is written.
- Replaces the simulation-only sink with a synthesizable block.

Parameters:
- DATA_WIDTH, 12, width of each I/Q sample
- ADDR_WIDTH, 16, result memory address width
- CONFIG_WIDTH, 32, width of length field

Ports:
- clk  in  1  system clock, all logic on posedge
- rstn  in  1  asynchronous reset, active low
- start_i  in  1  single-cycle start request, sampled only in IDLE
- len_i  in  CONFIG_WIDTH  number of IQ pairs to drain, sampled with start_i
- Empty_i  in  1  OR of I and Q output FIFO empty flags
- data_I_i  in  DATA_WIDTH  I FIFO read data, valid the cycle after Read_Enable_o
- data_Q_i  in  DATA_WIDTH  Q FIFO read data, valid the cycle after Read_Enable_o
- Read_Enable_o  out  1  read strobe to both output FIFOs
- Write_Enable_o  out  1  result memory write strobe
- addr_o  out  ADDR_WIDTH  result memory write address
- data_o  out  2*DATA_WIDTH  packed write data {Q,I}
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  one-cycle completion pulse
- count_o  out  CONFIG_WIDTH  pairs written so far

Behaviour:
- Reset (rstn low, async): state=IDLE. Read_Enable_o=0, Write_Enable_o=0, addr_o=0, data_o=0, busy_o=0, done_o=0, count_o=0, rd_cnt=0, len register=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_i=1 with len_i>0 -> latch len, clear rd_cnt, count_o and addr_o, go to RUN.
  - start_i=1 with len_i=0 -> go to DONE directly. No FIFO read, no memory write.
  - Other inputs are ignored.
- RUN:
  - Read_Enable_o is combinational: (state==RUN) && !Empty_i && (rd_cnt<len).
  - Never asserted while Empty_i=1; reading an empty FIFO is forbidden.
  - Each read increments rd_cnt.
  - When the final read issues (rd_cnt==len-1 and read asserted), go to DRAIN next cycle.
- Write path, 1-cycle latency, active in RUN and DRAIN:
  - The cycle after any read, Write_Enable_o=1 (registered), data_o={data_Q_i,data_I_i} taken from the FIFO outputs, addr_o=current write address.
  - After each write, the address increments and count_o increments.
  - Back-to-back reads give back-to-back writes; one pair per clock is sustained when not empty.
- Address width: addr_o is count_o[ADDR_WIDTH-1:0]. When len > 2**ADDR_WIDTH the address wraps modulo 2**ADDR_WIDTH; count_o does not wrap.
- DRAIN: the final write completes in this state, then go to DONE.
- DONE: done_o=1 for exactly one cycle, then go to IDLE. count_o holds its final value until the next accepted start.
- busy_o=1 in RUN and DRAIN only.
- start_i in RUN, DRAIN or DONE is ignored. It is not queued.
- Empty_i toggling mid-transfer: reads stall with no write bubble penalty beyond the stall. Write ordering is preserved.
- Reset mid-operation: immediate return to reset values. Partially written memory content is left as is. No done pulse.

Test Plan:
- Basic drain:
  - Stimulus: FIFOs preloaded with I=0x001..0x004, Q=0x101..0x104; start with len=4.
  - Required: 4 consecutive reads, then writes at addr 0..3 with data_o 0x101001, 0x102002, 0x103003, 0x104004. done_o pulses 2 cycles after the last read; count_o=4.
- Empty stalls:
  - Stimulus: len=3, with one sample available every 3 cycles.
  - Required: Read_Enable_o is never high while Empty_i=1. Writes land at addr 0,1,2 in order. done_o=1 once; busy_o is low afterwards.
- Zero length:
  - Stimulus: start with len=0.
  - Required: no Read_Enable_o and no Write_Enable_o. done_o pulses on the cycle after start; busy_o stays 0.
- Start ignored while busy:
  - Stimulus: start with len=5, then pulse start_i again with len=2 during RUN.
  - Required: exactly 5 writes (addr 0..4), count_o=5, a single done pulse.
- Reset mid-transfer:
  - Stimulus: len=6; assert rstn low after 3 writes, release, then start with len=2.
  - Required: outputs go to 0 immediately on reset and there is no done pulse. The new run writes addr 0,1 and done_o pulses.
- Address wrap:
  - Stimulus: ADDR_WIDTH=3, len=10, FIFO never empty.
  - Required: addr_o sequence is 0..7,0,1; count_o ends at 10; done_o pulses once.
